// File: rtl/rr_arbiter_param.sv
// Parameterised N-port arbiter with fixed-priority or round-robin selection,
// a held grant until ack, and an optional grant timeout.
module rr_arbiter_param #(
  parameter int unsigned NUM_PORTS = 8,
  parameter int unsigned PORT_W    = 3,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] port_req,
  input  logic                 cfg_arb_scheme,
  input  logic                 gnt_ack,
  output logic                 gnt_valid,
  output logic [PORT_W-1:0]    gnt_port,
  output logic [NUM_PORTS-1:0] gnt_onehot,
  output logic [PORT_W-1:0]    high_priority,
  output logic                 gnt_timeout
);

  localparam int unsigned     SUM_W       = PORT_W + 1;
  localparam logic [SUM_W-1:0] NUM_PORTS_S = SUM_W'(NUM_PORTS);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   valid_d, timeout_d;
  logic [PORT_W-1:0]      port_d, hp_d;
  logic [NUM_PORTS-1:0]   onehot_d;

  logic [PORT_W-1:0]      base, off, win_port, next_hp;
  logic [2*NUM_PORTS-1:0] req_dbl;
  logic [NUM_PORTS-1:0]   req_rot;
  logic [SUM_W-1:0]       sum, hp_sum;
  logic                   win_found;
  logic                   timeout_hit;

  // Rotate requests so the search start sits at bit 0, then take the lowest set bit
  always_comb begin
    base      = cfg_arb_scheme ? high_priority : '0;
    req_dbl   = {port_req, port_req};
    req_rot   = NUM_PORTS'(req_dbl >> base);
    win_found = 1'b0;
    off       = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!win_found && req_rot[i]) begin
        win_found = 1'b1;
        off       = PORT_W'(i);
      end
    end
    sum = SUM_W'(base) + SUM_W'(off);
    if (sum >= NUM_PORTS_S) sum = sum - NUM_PORTS_S;
    win_port = PORT_W'(sum);
  end

  // Round-robin pointer moves to the port after the released grantee
  always_comb begin
    hp_sum = SUM_W'(gnt_port) + SUM_W'(1);
    if (hp_sum >= NUM_PORTS_S) hp_sum = hp_sum - NUM_PORTS_S;
    next_hp = PORT_W'(hp_sum);
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = gnt_valid;
    port_d    = gnt_port;
    onehot_d  = gnt_onehot;
    hp_d      = high_priority;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        valid_d  = 1'b0;
        port_d   = '0;
        onehot_d = '0;
        cnt_d    = '0;
        if (win_found) begin
          state_d  = GRANT;
          valid_d  = 1'b1;
          port_d   = win_port;
          onehot_d = NUM_PORTS'(1) << win_port;
        end
      end
      GRANT: begin
        // Ack takes precedence over a timeout landing in the same cycle
        if (gnt_ack || timeout_hit) begin
          state_d   = IDLE;
          valid_d   = 1'b0;
          port_d    = '0;
          onehot_d  = '0;
          cnt_d     = '0;
          timeout_d = !gnt_ack;
          if (cfg_arb_scheme) hp_d = next_hp;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      gnt_valid     <= 1'b0;
      gnt_port      <= '0;
      gnt_onehot    <= '0;
      high_priority <= '0;
      gnt_timeout   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gnt_valid     <= valid_d;
      gnt_port      <= port_d;
      gnt_onehot    <= onehot_d;
      high_priority <= hp_d;
      gnt_timeout   <= timeout_d;
    end
  end

endmodule
